// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer, the ALU and the control unit:
// 3-bit ALU control codes, MIPS R-type funct values and the sequencer
// FSM state type.
package alu_sequencer_pkg;

    // ALU control codes, as seen on the ALU's ALUControl input
    localparam logic [2:0] ALU_CTRL_AND = 3'b000;
    localparam logic [2:0] ALU_CTRL_OR  = 3'b001;
    localparam logic [2:0] ALU_CTRL_ADD = 3'b010;
    localparam logic [2:0] ALU_CTRL_XOR = 3'b011;
    localparam logic [2:0] ALU_CTRL_SLL = 3'b100;
    localparam logic [2:0] ALU_CTRL_SRL = 3'b101;
    localparam logic [2:0] ALU_CTRL_SUB = 3'b110;
    localparam logic [2:0] ALU_CTRL_SLT = 3'b111;

    // MIPS R-type funct field values understood by the sequencer
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // Statistics counter width and saturation value
    localparam int          STAT_WIDTH = 16;
    localparam logic [15:0] STAT_MAX   = 16'hFFFF;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_e;

    // Saturating increment used by the statistics counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        sat_inc16 = (value == STAT_MAX) ? STAT_MAX : value + 16'd1;
    endfunction

endpackage

// File: rtl/alu_sequencer_funct_decode.sv
// Combinational MIPS R-type funct decoder (module alu_funct_decode).
// Maps a funct field to the 3-bit ALU control code and flags values the
// ALU cannot execute. Illegal values report ADD as a harmless default code.
module alu_funct_decode
    import alu_sequencer_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] ctrl,
    output logic       illegal
);

    // Funct-to-control lookup; anything outside the table is illegal
    always_comb begin
        ctrl    = ALU_CTRL_ADD;
        illegal = 1'b0;
        case (funct)
            FUNCT_AND: ctrl = ALU_CTRL_AND;
            FUNCT_OR:  ctrl = ALU_CTRL_OR;
            FUNCT_ADD: ctrl = ALU_CTRL_ADD;
            FUNCT_XOR: ctrl = ALU_CTRL_XOR;
            FUNCT_SLL: ctrl = ALU_CTRL_SLL;
            FUNCT_SRL: ctrl = ALU_CTRL_SRL;
            FUNCT_SUB: ctrl = ALU_CTRL_SUB;
            FUNCT_SLT: ctrl = ALU_CTRL_SLT;
            default: begin
                ctrl    = ALU_CTRL_ADD;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts one R-type request at a time, drives registered
// operands/control to an external combinational ALU for one EXEC cycle,
// captures the result and holds it as a response until consumed.
// Optional build macro ALU_SEQ_STATS_EN adds saturating op/err counters.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]      op_count,
    output logic [15:0]      err_count
`endif
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic [2:0]       dec_ctrl;
    logic             dec_illegal;

    alu_funct_decode u_decode (
        .funct   (req_funct),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal)
    );

    // Handshake-visible status comes straight from the state register
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and datapath capture; everything holds unless a state acts
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_ctrl_d = alu_ctrl_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    alu_a_d    = req_a;
                    alu_b_d    = req_b;
                    alu_ctrl_d = dec_ctrl;
                    if (dec_illegal) begin
                        // Nothing for the ALU to do: respond with an error
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        state_d    = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                // The ALU has had a full cycle on registered operands
                rsp_data_d = alu_result;
                rsp_err_d  = 1'b0;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                // Return to IDLE only; a new request waits for the next cycle
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_ctrl_q <= ALU_CTRL_ADD;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_ctrl_q <= alu_ctrl_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic        rsp_fire;
    logic [15:0] op_count_q, op_count_d;
    logic [15:0] err_count_q, err_count_d;

    assign rsp_fire  = rsp_valid & rsp_ready;
    assign op_count  = op_count_q;
    assign err_count = err_count_q;

    // Count completed response handshakes, split by error flag, saturating
    always_comb begin
        op_count_d  = op_count_q;
        err_count_d = err_count_q;
        if (rsp_fire) begin
            if (rsp_err_q) begin
                err_count_d = sat_inc16(err_count_q);
            end else begin
                op_count_d  = sat_inc16(op_count_q);
            end
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q  <= '0;
            err_count_q <= '0;
        end else begin
            op_count_q  <= op_count_d;
            err_count_q <= err_count_d;
        end
    end
`endif

endmodule
